pipelined_mux_tree: RTL
=======================

Name: pipelined_mux_tree

Overview:
- Parametrised N:1 selector, N = 2**SEL_W lanes of DATA_W bits each.
- Built as a binary 2:1 reduction tree with pipeline registers every PIPE_EVERY levels, so wide muxes (1024:1 and larger) close timing on the FPGA fabric.
- Adds a valid-tagged streaming interface, a returned select tag, and an internal scan mode that sweeps all lanes automatically.
- Used as an I/O-stress benchmark block and as a lane-sweep source for capacity tests.

Parameters:
- DATA_W, 1, bit width of each lane and of out.
- SEL_W, 10, number of select bits; tree depth; N = 2**SEL_W lanes (legal range 1..12).
- PIPE_EVERY, 3, tree levels between pipeline registers (legal range 1..SEL_W).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in  input  N*DATA_W  lane data; lane i = in[i*DATA_W +: DATA_W].
- sel  input  SEL_W  lane select, used when scan_en=0.
- in_valid  input  1  qualifies in/sel (or a scan step) this cycle.
- scan_en  input  1  1 = select comes from internal scan counter.
- out  output  DATA_W  selected lane data.
- out_valid  output  1  out/out_sel are a valid result.
- out_sel  output  SEL_W  effective select that produced out.
- out_last  output  1  result came from lane N-1 while in scan mode.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline data/tag/valid registers clear to 0, scan_cnt clears to 0. Outputs after reset: out=0, out_valid=0, out_sel=0, out_last=0.
- Reset release is synchronous to clk. Reset mid-operation discards all in-flight results; no partial output is produced.
- Effective select: eff_sel = scan_en ? scan_cnt : sel.
- Tree structure:
  - Level k (k = 0..SEL_W-1) halves the candidate set using eff_sel[k], LSB first.
  - Pair (2j, 2j+1): eff_sel[k]=0 picks the even element, 1 picks the odd element.
  - Result for any eff_sel equals in lane eff_sel, bit-exact.
- Pipeline registers:
  - Inserted after level PIPE_EVERY-1, 2*PIPE_EVERY-1, ..., and always after level SEL_W-1 (no duplicate register if these coincide).
  - Latency L = ceil(SEL_W/PIPE_EVERY) cycles from in_valid sampled high to out_valid high. Defaults: L=4.
- Each register stage carries:
  - the partial data;
  - the unused upper eff_sel bits;
  - the full eff_sel as a tag;
  - a valid bit;
  - a last flag.
- Full throughput: one result per cycle, no backpressure; pipeline advances every cycle.
- Data/tag registers of a stage load only when the incoming valid bit is 1, otherwise they hold. Therefore out/out_sel hold their last valid values while out_valid=0. The valid bit and last flag always load.
- out_valid is high for exactly one cycle per accepted in_valid. Back-to-back in_valid gives back-to-back out_valid in the same order.
- Scan counter:
  - scan_cnt increments by 1 on each clk edge where scan_en=1 and in_valid=1.
  - Wraps N-1 -> 0.
  - Cleared to 0 synchronously on any cycle with scan_en=0.
  - in_valid=0 in scan mode: counter holds.
- out_last: the registered tag of scan_en=1 AND eff_sel=N-1; appears with that result's out_valid.
- scan_en toggling mid-stream:
  - Results already in the pipe complete unchanged (tags travel with data).
  - A new scan always starts at lane 0.
- The in and sel ports are not registered at the input; they must be stable only in the cycle in_valid is sampled.

Test Plan (defaults DATA_W=1, SEL_W=10, PIPE_EVERY=3, L=4 unless stated):
- Static select: in = one-hot at lane 700, sel=700, in_valid pulse at cycle t -> out_valid=1, out=1, out_sel=700, out_last=0 at cycle t+4 only. sel=699 gives out=0.
- Streaming: in_valid held high for 8 cycles, sel=0,1,...,7, in=0xAA pattern on lanes 0-7 -> 8 consecutive out_valid cycles with out=0,1,0,1,0,1,0,1 and out_sel=0..7. out holds 1 after the stream.
- Scan wrap: SEL_W=3, in=8'b1011_0010, scan_en=1, in_valid high 10 cycles -> out_sel=0,1,...,7,0,1 and out=0,1,0,0,1,1,0,1,0,1. out_last=1 only on the out_sel=7 result.
- Scan restart: scan_en drops for 1 cycle after lane 5 is issued, then returns -> next scan result has out_sel=0. In-flight lane 4/5 results still emerge correctly.
- Async reset mid-stream: assert rst_n=0 between clock edges with 3 results in flight -> out_valid, out, out_sel, out_last go 0 immediately. After release with in_valid=0, no out_valid appears within 6 cycles.
- Parameter sweep: PIPE_EVERY=1 (L=10), PIPE_EVERY=10 (L=1), DATA_W=8 with random lanes and sels -> out matches in lane sel with latency L exactly, 1000 random vectors each.

Source files
------------

// File: rtl/pipelined_mux_tree.sv
// N:1 lane selector built as a pipelined binary 2:1 reduction tree, with
// valid-tagged streaming, a returned select tag and an automatic lane-scan mode.
module pipelined_mux_tree #(
  parameter int DATA_W     = 1,
  parameter int SEL_W      = 10,
  parameter int PIPE_EVERY = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [(2**SEL_W)*DATA_W-1:0]   in,
  input  logic [SEL_W-1:0]               sel,
  input  logic                           in_valid,
  input  logic                           scan_en,
  output logic [DATA_W-1:0]              out,
  output logic                           out_valid,
  output logic [SEL_W-1:0]               out_sel,
  output logic                           out_last
);

  localparam int N      = 2**SEL_W;
  localparam int STAGES = (SEL_W + PIPE_EVERY - 1) / PIPE_EVERY;

  // Lanes alive at segment k: segment 0 is the raw input, segment k>0 is the
  // output of register stage k-1.
  function automatic int seg_lanes(input int k);
    int lvl;
    lvl = k * PIPE_EVERY;
    if (lvl > SEL_W) lvl = SEL_W;
    return 1 << (SEL_W - lvl);
  endfunction

  function automatic int seg_off(input int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++) o += seg_lanes(i) * DATA_W;
    return o;
  endfunction

  localparam int SEG_TOTAL = seg_off(STAGES + 1);
  localparam int OUT_OFF   = seg_off(STAGES);

  // All segments packed back to back; each slice has exactly one driver.
  logic [SEG_TOTAL-1:0] seg_data;
  logic [SEL_W-1:0]     seg_tag   [STAGES+1];
  logic                 seg_valid [STAGES+1];
  logic                 seg_last  [STAGES+1];

  logic [SEL_W-1:0] scan_cnt;
  logic [SEL_W-1:0] eff_sel;

  assign eff_sel = scan_en ? scan_cnt : sel;

  // NOTE: sequential state uses non-blocking assignments only, so the order in
  // which clocked blocks evaluate within a cycle can never change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (!scan_en) begin
      scan_cnt <= '0;
    end else if (in_valid) begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign seg_data[N*DATA_W-1:0] = in;
  assign seg_tag[0]             = eff_sel;
  assign seg_valid[0]           = in_valid;
  assign seg_last[0]            = in_valid & scan_en & (&eff_sel);

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO      = s * PIPE_EVERY;
    localparam int HI      = (LO + PIPE_EVERY < SEL_W) ? LO + PIPE_EVERY : SEL_W;
    localparam int W_IN    = seg_lanes(s) * DATA_W;
    localparam int W_OUT   = seg_lanes(s + 1) * DATA_W;
    localparam int OFF_IN  = seg_off(s);
    localparam int OFF_OUT = seg_off(s + 1);

    logic [W_IN-1:0]  work;
    logic [W_OUT-1:0] data_q;
    logic [SEL_W-1:0] tag_q;
    logic             valid_q;
    logic             last_q;

    // Levels LO..HI-1 reduce in place: pair (2j, 2j+1) collapses into slot j,
    // which never overwrites a pair still to be read at the same level. The
    // select bits still unused travel inside the tag, so they come from there.
    // NOTE: work is fully assigned before the reduction loops, so every path
    // through this block drives it and no latch can be inferred.
    always_comb begin
      work = seg_data[OFF_IN +: W_IN];
      for (int lvl = LO; lvl < HI; lvl++) begin
        for (int j = 0; j < (1 << (SEL_W - lvl - 1)); j++) begin
          work[j*DATA_W +: DATA_W] = seg_tag[s][lvl] ? work[(2*j+1)*DATA_W +: DATA_W]
                                                      : work[(2*j)*DATA_W +: DATA_W];
        end
      end
    end

    // NOTE: data and tag are plain registers, not memories, and are reset so
    // that out/out_sel read 0 after reset instead of stale lane data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        tag_q   <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        valid_q <= seg_valid[s];
        last_q  <= seg_last[s];
        if (seg_valid[s]) begin
          data_q <= work[W_OUT-1:0];
          tag_q  <= seg_tag[s];
        end
      end
    end

    assign seg_data[OFF_OUT +: W_OUT] = data_q;
    assign seg_tag[s+1]               = tag_q;
    assign seg_valid[s+1]             = valid_q;
    assign seg_last[s+1]              = last_q;
  end

  assign out       = seg_data[OUT_OFF +: DATA_W];
  assign out_valid = seg_valid[STAGES];
  assign out_sel   = seg_tag[STAGES];
  assign out_last  = seg_last[STAGES];

endmodule
